comparator_multicycle: RTL

//  Multi-cycle, multi-mode N-bit comparator. It scans operands W bits per cycle, MSB chunk first.

---
 rtl/comparator_pkg.sv | 26 ++
 rtl/comparator_chunk.sv | 15 +
 rtl/comparator_multicycle.sv | 92 +++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// comparator_pkg: shared comparison modes, FSM states and result helpers
package comparator_pkg;
  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_LTU = 3'd3,
    CMP_GE  = 3'd4,
    CMP_GEU = 3'd5
  } cmp_mode_t;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;
  function automatic logic is_signed(cmp_mode_t m);
    return !(m == CMP_LTU || m == CMP_GEU);
  endfunction
  // Reserved encodings 6 and 7 fall through to 0.
  function automatic logic cmp_result(logic [2:0] m, logic eq, logic lt);
    return m == CMP_EQ ? eq :
           m == CMP_NE ? !eq :
           (m == CMP_LT || m == CMP_LTU) ? lt :
           (m == CMP_GE || m == CMP_GEU) ? !lt : 1'b0;
  endfunction
endpackage

// File: rtl/comparator_chunk.sv
// comparator_chunk: combinational W-bit eq/lt; signed_top flips the MSB so an unsigned compare orders two's complement
module comparator_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         signed_top,
  output logic         eq,
  output logic         lt
);
  logic [W-1:0] flip;
  assign flip = W'(signed_top) << (W - 1);
  assign eq = a == b;
  assign lt = (a ^ flip) < (b ^ flip);
endmodule

// File: rtl/comparator_multicycle.sv
// comparator_multicycle: N-bit multi-mode comparator scanning W bits per cycle, MSB chunk first.
// Define COMPARATOR_EARLY_EXIT_EN to finish on the first differing chunk.
module comparator_multicycle
  import comparator_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out,
  output logic         out_eq,
  output logic         out_lt
);
  localparam int CHUNKS = N / W;
  localparam int IW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
  if (N % W != 0 || N < W) begin : g_bad
    $error("comparator_multicycle: N must be a non-zero multiple of W");
  end
  state_t         state;
  logic [N-1:0]   a_r, b_r;
  logic [2:0]     mode_r;
  logic [IW-1:0]  idx;
  logic           decided, lt;
  logic [W-1:0]   ca, cb;
  logic           c_eq, c_lt, top, dec_n, lt_n, fin;
  assign ca = a_r[int'(idx)*W +: W];
  assign cb = b_r[int'(idx)*W +: W];
  assign top = idx == IW'(CHUNKS - 1);
  comparator_chunk #(.W(W)) u_chunk (
    .a          (ca),
    .b          (cb),
    .signed_top (top && is_signed(cmp_mode_t'(mode_r))),
    .eq         (c_eq),
    .lt         (c_lt)
  );
  assign dec_n = decided || !c_eq;
  assign lt_n = decided ? lt : !c_eq && c_lt;
`ifdef COMPARATOR_EARLY_EXIT_EN
  assign fin = idx == '0 || dec_n;
`else
  assign fin = idx == '0;
`endif
  assign in_ready = state == S_IDLE;
  assign out_valid = state == S_DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      mode_r  <= '0;
      idx     <= IW'(CHUNKS - 1);
      decided <= 1'b0;
      lt      <= 1'b0;
      out     <= 1'b0;
      out_eq  <= 1'b0;
      out_lt  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          a_r     <= a;
          b_r     <= b;
          mode_r  <= mode;
          idx     <= IW'(CHUNKS - 1);
          decided <= 1'b0;
          lt      <= 1'b0;
          state   <= S_BUSY;
        end
        S_BUSY: begin
          decided <= dec_n;
          lt      <= lt_n;
          idx     <= idx - IW'(1);
          if (fin) begin
            out    <= cmp_result(mode_r, !dec_n, lt_n);
            out_eq <= !dec_n;
            out_lt <= lt_n;
            state  <= S_DONE;
          end
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
